// File: rtl/timer_bus_arb.sv
// Round-robin two-master arbiter in front of the timer register port.
// A master can lock the port for an atomic read-modify-write; a bounded counter force-releases a stuck lock.
module timer_bus_arb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              wen_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              lock_err_o
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    state_t      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        lock_err_q, lock_err_d;
    logic        rd_pend_q, rd_owner_q;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        timeout;
    logic [ADDR_W-1:0] addr_mux;

    // Requests are masked while reset is held so every output stays quiet.
    assign req0 = m0_req_i & rst_n_i;
    assign req1 = m1_req_i & rst_n_i;

    // Grant selection, lock tracking and timeout detection.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        lock_err_d = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !rr_ptr_q)) begin
                    gnt0 = 1'b1;
                end else if (req1) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 || gnt1) begin
                    rr_ptr_d = gnt0;
                end
                if (gnt0 && m0_lock_i) begin
                    state_d    = LOCK0;
                    lock_cnt_d = 8'd1;
                end else if (gnt1 && m1_lock_i) begin
                    state_d    = LOCK1;
                    lock_cnt_d = 8'd1;
                end
            end
            LOCK0: begin
                gnt0       = req0;
                timeout    = (lock_cnt_q >= MAX_CNT);
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (gnt0 && !m0_lock_i) begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                end else if (timeout) begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                    lock_err_d = 1'b1;
                    rr_ptr_d   = 1'b1;
                end
            end
            LOCK1: begin
                gnt1       = req1;
                timeout    = (lock_cnt_q >= MAX_CNT);
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (gnt1 && !m1_lock_i) begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                end else if (timeout) begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                    lock_err_d = 1'b1;
                    rr_ptr_d   = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    // Arbitration state and the one-deep read-response tracker.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            lock_cnt_q <= 8'd0;
            lock_err_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
            rd_pend_q  <= (gnt0 & ~m0_we_i) | (gnt1 & ~m1_we_i);
            rd_owner_q <= gnt1;
        end
    end

    // Winner's beat is steered onto the timer port; zero when nobody wins.
    always_comb begin
        addr_mux = '0;
        wdata_o  = '0;
        wen_o    = 1'b0;
        if (gnt0) begin
            addr_mux = m0_addr_i;
            wdata_o  = m0_wdata_i;
            wen_o    = m0_we_i;
        end else if (gnt1) begin
            addr_mux = m1_addr_i;
            wdata_o  = m1_wdata_i;
            wen_o    = m1_we_i;
        end
    end

    assign waddr_o     = addr_mux;
    assign raddr_o     = addr_mux;
    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign lock_err_o  = lock_err_q;
    assign m0_rvalid_o = rd_pend_q & ~rd_owner_q;
    assign m1_rvalid_o = rd_pend_q & rd_owner_q;
    assign m0_rdata_o  = m0_rvalid_o ? rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_i : '0;

endmodule
